// File: rtl/inv_shift_sub_serial.sv
//==============================================================================
// inv_shift_sub_serial : InvShiftRows + InvSubBytes, LANES S-box lanes per clock.
// Optional build macro: INV_SBOX_FAULT_DET_EN (forward-S-box self-check). Rev 1.0
//==============================================================================
`default_nettype none

module inv_shift_sub_serial #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] InvMixColumns_Matrix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] InvSubBytes_Matrix,
  output logic         busy,
  output logic         sbox_fault
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Entry x lives at bits [8x +: 8]; ascending range keeps the table in reading order.
  localparam logic [0:2047] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SBOX_FAULT_DET_EN
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      t_q   [16];
  logic [7:0]      t_d   [16];
  logic [7:0]      res_q [16];
  logic [7:0]      res_d [16];
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [7:0]      in_byte  [16];
  logic [3:0]      lane_idx [LANES];
  logic [7:0]      lane_out [LANES];

  for (genvar k = 0; k < 16; k++) begin : g_bytes
    assign in_byte[k]                  = InvMixColumns_Matrix[8*k +: 8];
    assign InvSubBytes_Matrix[8*k +: 8] = res_q[k];
  end

`ifdef INV_SBOX_FAULT_DET_EN
  logic [LANES-1:0] lane_mism;
  logic             fault_q, fault_d;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] sub_in;
    logic [7:0] sub_out;
    assign lane_idx[l] = 4'(LANES * int'(cnt_q) + l);
    assign sub_in      = t_q[lane_idx[l]];
    assign sub_out     = INV_SBOX_TBL[{sub_in, 3'b000} +: 8];
    assign lane_out[l] = sub_out;
`ifdef INV_SBOX_FAULT_DET_EN
    // Round-trip check: S(InvS(x)) must reproduce the lane's input byte.
    assign lane_mism[l] = (SBOX_TBL[{sub_out, 3'b000} +: 8] != sub_in);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    res_d   = res_q;
`ifdef INV_SBOX_FAULT_DET_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
              t_d[4*c + r] = in_byte[4*((c - r + 4) % 4) + r];
            end
          end
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[lane_idx[l]] = lane_out[l];
        end
`ifdef INV_SBOX_FAULT_DET_EN
        fault_d = fault_q | (|lane_mism);
`endif
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_q         <= '{default: '0};
      res_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INV_SBOX_FAULT_DET_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef INV_SBOX_FAULT_DET_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef INV_SBOX_FAULT_DET_EN
  assign sbox_fault = fault_q;
`else
  assign sbox_fault = 1'b0;
`endif

endmodule

`default_nettype wire
